// File: rtl/axil_wb_bridge_mc_if.sv
// AXI4-Lite channel bundle shared by the bridge and its masters.
// Only the Slave modport is used by the bridge; Master serves the driving side.
interface AXI_LITE #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]                  aw_prot;
  logic                        aw_valid;
  logic                        aw_ready;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_valid;
  logic                        w_ready;
  logic [1:0]                  b_resp;
  logic                        b_valid;
  logic                        b_ready;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]                  ar_prot;
  logic                        ar_valid;
  logic                        ar_ready;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_valid;
  logic                        r_ready;

  modport Slave (
    input  aw_addr, aw_prot, aw_valid, output aw_ready,
    input  w_data, w_strb, w_valid,    output w_ready,
    output b_resp, b_valid,            input  b_ready,
    input  ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid,    input  r_ready
  );

  modport Master (
    output aw_addr, aw_prot, aw_valid, input  aw_ready,
    output w_data, w_strb, w_valid,    input  w_ready,
    input  b_resp, b_valid,            output b_ready,
    output ar_addr, ar_prot, ar_valid, output r_ready,
    input  ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axil_wb_bridge_mc.sv
// AXI4-Lite slave to multi-target Wishbone master: one transaction at a time,
// address decode, error/timeout mapping and alternating read/write grant.
module axil_wb_bridge_mc #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_WB         = 2,
  parameter logic [NUM_WB-1:0][ADDR_WIDTH-1:0] BASE_ADDR = {NUM_WB{ADDR_WIDTH'(0)}},
  parameter logic [NUM_WB-1:0][ADDR_WIDTH-1:0] ADDR_MASK = {NUM_WB{ADDR_WIDTH'(32'hFFFF_F000)}},
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  AXI_LITE.Slave                       slave,
  output logic [ADDR_WIDTH-1:0]        wb_adr_o,
  output logic [DATA_WIDTH-1:0]        wb_dat_o,
  output logic [DATA_WIDTH/8-1:0]      wb_sel_o,
  output logic                         wb_we_o,
  output logic [NUM_WB-1:0]            wb_cyc_o,
  output logic [NUM_WB-1:0]            wb_stb_o,
  input  logic [NUM_WB*DATA_WIDTH-1:0] wb_dat_i,
  input  logic [NUM_WB-1:0]            wb_ack_i,
  input  logic [NUM_WB-1:0]            wb_err_i,
  output logic                         timeout_o
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, WB_CYC, RESP_R, RESP_B} state_e;

  state_e                  state_q, state_d;
  logic                    last_wr_q, last_wr_d;
  logic [NUM_WB-1:0]       cyc_q, cyc_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [STRB_W-1:0]       sel_q, sel_d;
  logic                    we_q, we_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              resp_q, resp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    r_valid_q, r_valid_d;
  logic                    b_valid_q, b_valid_d;
  logic                    timeout_q, timeout_d;

  logic                    grant_wr_c, grant_rd_c;
  logic [ADDR_WIDTH-1:0]   cand_addr_c;
  logic [NUM_WB-1:0]       tgt_c;
  logic [DATA_WIDTH-1:0]   sel_rdata_c;
  logic                    sel_ack_c, sel_err_c, wb_done_c;
  logic                    prot_unused;

  assign prot_unused = ^{slave.aw_prot, slave.ar_prot};

  // Candidate selection: on contention the side not served last wins.
  always_comb begin
    grant_wr_c  = 1'b0;
    grant_rd_c  = 1'b0;
    cand_addr_c = slave.ar_addr;
    tgt_c       = '0;
    if (state_q == IDLE) begin
      grant_wr_c = slave.aw_valid && slave.w_valid && (!slave.ar_valid || !last_wr_q);
      grant_rd_c = slave.ar_valid && !grant_wr_c;
    end
    if (grant_wr_c) cand_addr_c = slave.aw_addr;
    // Walk downwards so the lowest matching index is the one left standing.
    for (int i = int'(NUM_WB) - 1; i >= 0; i--) begin
      if ((cand_addr_c & ADDR_MASK[i]) == BASE_ADDR[i]) begin
        tgt_c    = '0;
        tgt_c[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rdata_c = '0;
    for (int i = 0; i < int'(NUM_WB); i++) begin
      if (cyc_q[i]) sel_rdata_c = wb_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
    sel_ack_c = |(wb_ack_i & cyc_q);
    sel_err_c = |(wb_err_i & cyc_q);
  end

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    cyc_d     = cyc_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    r_valid_d = r_valid_q;
    b_valid_d = b_valid_q;
    timeout_d = 1'b0;
    wb_done_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_wr_c || grant_rd_c) begin
          last_wr_d = grant_wr_c;
          adr_d     = cand_addr_c;
          we_d      = grant_wr_c;
          sel_d     = grant_wr_c ? slave.w_strb : '1;
          cnt_d     = '0;
          if (grant_wr_c) dat_d = slave.w_data;
          if (|tgt_c) begin
            cyc_d   = tgt_c;
            state_d = WB_CYC;
          end else begin
            resp_d    = RESP_DECERR;
            rdata_d   = '0;
            r_valid_d = grant_rd_c;
            b_valid_d = grant_wr_c;
            state_d   = grant_wr_c ? RESP_B : RESP_R;
          end
        end
      end
      WB_CYC: begin
        if (sel_err_c) begin
          resp_d    = RESP_SLVERR;
          rdata_d   = '0;
          wb_done_c = 1'b1;
        end else if (sel_ack_c) begin
          resp_d    = RESP_OKAY;
          rdata_d   = we_q ? '0 : sel_rdata_c;
          wb_done_c = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          resp_d    = RESP_SLVERR;
          rdata_d   = '0;
          timeout_d = 1'b1;
          wb_done_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (wb_done_c) begin
          cyc_d     = '0;
          r_valid_d = !we_q;
          b_valid_d = we_q;
          state_d   = we_q ? RESP_B : RESP_R;
        end
      end
      RESP_R: begin
        if (slave.r_ready) begin
          r_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      RESP_B: begin
        if (slave.b_ready) begin
          b_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b1;
      cyc_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      resp_q    <= '0;
      rdata_q   <= '0;
      r_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      cyc_q     <= cyc_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      r_valid_q <= r_valid_d;
      b_valid_q <= b_valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign slave.aw_ready = grant_wr_c;
  assign slave.w_ready  = grant_wr_c;
  assign slave.ar_ready = grant_rd_c;
  assign slave.r_valid  = r_valid_q;
  assign slave.r_data   = rdata_q;
  assign slave.r_resp   = resp_q;
  assign slave.b_valid  = b_valid_q;
  assign slave.b_resp   = resp_q;

  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign timeout_o = timeout_q;
endmodule

// File: tb/tb_axil_wb_bridge_mc.sv
// Bench for axil_wb_bridge_mc: directed protocol steps followed by random traffic
// checked against a word-level memory map model.
module tb_axil_wb_bridge_mc;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 2;
  localparam int unsigned TO = 16;
  localparam int M_ACK = 0, M_ERR = 1, M_NEVER = 2, M_BOTH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  AXI_LITE #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) axi ();

  logic [AW-1:0]    wb_adr;
  logic [DW-1:0]    wb_dat;
  logic [3:0]       wb_sel;
  logic             wb_we;
  logic [NW-1:0]    wb_cyc, wb_stb, wb_ack, wb_err;
  logic [NW*DW-1:0] wb_dat_i;
  logic             timeout;

  axil_wb_bridge_mc #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WB(NW),
    .BASE_ADDR({32'h0000_1000, 32'h0000_0000}),
    .ADDR_MASK({32'hFFFF_F000, 32'hFFFF_F000}),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .slave(axi),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .timeout_o(timeout)
  );

  // Wishbone targets: small memories with programmable wait states and reply kind.
  int          tmode [NW];
  int unsigned twait [NW];
  int unsigned wcnt  [NW] = '{default: 0};
  logic [NW-1:0] late_ack  = '0;
  logic [NW-1:0] extra_err = '0;
  logic [31:0] mem   [NW][16] = '{default: '0};
  logic [31:0] model [NW][16] = '{default: '0};

  always @(posedge clk) begin
    for (int i = 0; i < int'(NW); i++) begin
      if (wb_stb[i]) begin
        wcnt[i] <= wcnt[i] + 1;
        if (wb_ack[i] && !wb_err[i] && wb_we)
          for (int b = 0; b < 4; b++)
            if (wb_sel[b]) mem[i][wb_adr[5:2]][b*8 +: 8] <= wb_dat[b*8 +: 8];
      end else begin
        wcnt[i] <= 0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NW); i++) begin
      wb_ack[i] = late_ack[i] | (wb_stb[i] && (tmode[i] == M_ACK || tmode[i] == M_BOTH) && wcnt[i] == twait[i]);
      wb_err[i] = extra_err[i] | (wb_stb[i] && (tmode[i] == M_ERR || tmode[i] == M_BOTH) && wcnt[i] == twait[i]);
      wb_dat_i[i*DW +: DW] = mem[i][wb_adr[5:2]];
    end
  end

  int cyc_n = 0, cyc_cycles = 0, to_pulses = 0, stb_diff = 0;
  logic [NW-1:0] last_cyc = '0;
  logic [3:0]    last_sel = '0;
  logic          last_we  = 1'b0;
  logic [31:0]   last_adr = '0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (wb_cyc != '0) begin
      cyc_cycles <= cyc_cycles + 1;
      last_cyc   <= wb_cyc;
      last_sel   <= wb_sel;
      last_we    <= wb_we;
      last_adr   <= wb_adr;
    end
    if (timeout) to_pulses <= to_pulses + 1;
    if (wb_cyc != wb_stb) stb_diff <= stb_diff + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int target_of(input logic [31:0] a);
    if ((a & 32'hFFFF_F000) == 32'h0000_0000) return 0;
    if ((a & 32'hFFFF_F000) == 32'h0000_1000) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // One AXI transaction; lat is cycles from handshake cycle to the cycle valid is seen.
  task automatic axi_txn(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [1:0] resp, output logic [31:0] rdata, output int lat);
    int n, hs;
    if (wr) begin
      axi.aw_addr = a; axi.w_data = d; axi.w_strb = s;
      axi.aw_valid = 1'b1; axi.w_valid = 1'b1;
    end else begin
      axi.ar_addr = a; axi.ar_valid = 1'b1;
    end
    #1;
    n = 0;
    while (!(wr ? (axi.aw_ready && axi.w_ready) : axi.ar_ready) && n < 64) begin
      @(posedge clk); #2; n++;
    end
    check("handshake_in_time", 64'(n < 64), 64'd1);
    hs = cyc_n;
    @(posedge clk); #1;
    axi.aw_valid = 1'b0; axi.w_valid = 1'b0; axi.ar_valid = 1'b0;
    axi.r_ready = 1'b1; axi.b_ready = 1'b1;
    n = 0;
    while (!(wr ? axi.b_valid : axi.r_valid) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("response_in_time", 64'(n < 200), 64'd1);
    lat   = cyc_n - hs;
    resp  = wr ? axi.b_resp : axi.r_resp;
    rdata = axi.r_data;
    @(posedge clk); #1;
    axi.r_ready = 1'b0; axi.b_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdata, d, a;
    logic [3:0]  s;
    int lat, c0, t0, n, t, idx, exp_lat, seen;
    bit wr;
    int g[$];
    int gc[$];

    axi.aw_addr = '0; axi.aw_prot = '0; axi.aw_valid = 1'b0;
    axi.w_data = '0; axi.w_strb = '0; axi.w_valid = 1'b0; axi.b_ready = 1'b0;
    axi.ar_addr = '0; axi.ar_prot = '0; axi.ar_valid = 1'b0; axi.r_ready = 1'b0;
    for (int i = 0; i < int'(NW); i++) begin tmode[i] = M_ACK; twait[i] = 0; end

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ar_ready", 64'(axi.ar_ready), 64'd0);
    check("rst_aw_ready", 64'(axi.aw_ready), 64'd0);
    check("rst_r_valid", 64'(axi.r_valid), 64'd0);
    check("rst_b_valid", 64'(axi.b_valid), 64'd0);
    check("rst_resp", 64'({axi.r_resp, axi.b_resp}), 64'd0);
    check("rst_r_data", 64'(axi.r_data), 64'd0);
    check("rst_cyc_stb", 64'({wb_cyc, wb_stb}), 64'd0);
    check("rst_adr_dat_sel_we", 64'({wb_adr, wb_dat} | 64'({wb_sel, wb_we})), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Arbitration under continuous contention: read first, then alternate, 3 cycles apart
    d = $urandom;
    axi.aw_addr = 32'h0000_1000; axi.w_data = d; axi.w_strb = 4'hF; axi.ar_addr = 32'h0000_0010;
    axi.aw_valid = 1'b1; axi.w_valid = 1'b1; axi.ar_valid = 1'b1;
    axi.r_ready = 1'b1; axi.b_ready = 1'b1;
    #1;
    for (int k = 0; k < 40 && g.size() < 4; k++) begin
      if (axi.ar_ready) begin g.push_back(0); gc.push_back(cyc_n); end
      if (axi.aw_ready && axi.w_ready) begin g.push_back(1); gc.push_back(cyc_n); end
      if (g.size() < 4) begin @(posedge clk); #2; end
    end
    @(posedge clk); #1;
    axi.aw_valid = 1'b0; axi.w_valid = 1'b0; axi.ar_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    axi.r_ready = 1'b0; axi.b_ready = 1'b0;
    model[1][0] = d;
    check("arb_grant_count", 64'(g.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("arb_order_%0d", k), 64'(k < g.size() ? g[k] : -1), 64'(k % 2));
    check("arb_spacing", 64'(g.size() == 4 ? gc[3] - gc[0] : -1), 64'd9);

    // AW without W is never accepted
    c0 = cyc_cycles; seen = 0;
    axi.aw_addr = 32'h0000_0020; axi.aw_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (axi.aw_ready || axi.w_ready) seen++;
      @(posedge clk); #1;
    end
    axi.aw_valid = 1'b0;
    check("aw_only_ready", 64'(seen), 64'd0);
    check("aw_only_no_cyc", 64'(cyc_cycles - c0), 64'd0);

    // Zero-wait read of target 0
    axi_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, resp, rdata, lat);
    model[0][4] = 32'hDEAD_BEEF;
    check("w0_resp", 64'(resp), 64'd0);
    check("w0_lat", 64'(lat), 64'd2);
    c0 = cyc_cycles;
    axi_txn(1'b0, 32'h0000_0010, '0, '0, resp, rdata, lat);
    check("r0_data", 64'(rdata), 64'hDEAD_BEEF);
    check("r0_resp", 64'(resp), 64'd0);
    check("r0_lat", 64'(lat), 64'd2);
    check("r0_cyc_len", 64'(cyc_cycles - c0), 64'd1);
    check("r0_cyc_sel", 64'(last_cyc), 64'b01);
    check("r0_we_sel", 64'({last_we, last_sel}), 64'h0F);

    // Write to target 1 with three wait states
    twait[1] = 3; c0 = cyc_cycles;
    axi_txn(1'b1, 32'h0000_1004, 32'h1234_5678, 4'b0011, resp, rdata, lat);
    model[1][1] = merge(model[1][1], 32'h1234_5678, 4'b0011);
    check("w1_resp", 64'(resp), 64'd0);
    check("w1_cyc_len", 64'(cyc_cycles - c0), 64'd4);
    check("w1_cyc_sel", 64'(last_cyc), 64'b10);
    check("w1_we_sel", 64'({last_we, last_sel}), 64'h13);
    check("w1_adr", 64'(last_adr), 64'h1004);
    check("w1_lat", 64'(lat), 64'd5);
    axi_txn(1'b0, 32'h0000_1004, '0, '0, resp, rdata, lat);
    check("w1_readback", 64'(rdata), 64'(model[1][1]));

    // Decode errors on read and write
    c0 = cyc_cycles;
    axi_txn(1'b0, 32'h0000_8000, '0, '0, resp, rdata, lat);
    check("dec_r_resp", 64'(resp), 64'd3);
    check("dec_r_data", 64'(rdata), 64'd0);
    check("dec_r_lat", 64'(lat), 64'd1);
    axi_txn(1'b1, 32'h0000_8004, 32'hFFFF_FFFF, 4'hF, resp, rdata, lat);
    check("dec_w_resp", 64'(resp), 64'd3);
    check("dec_no_cyc", 64'(cyc_cycles - c0), 64'd0);

    // Target error, err beating ack, and err on an unselected target
    tmode[0] = M_ERR; twait[0] = 1;
    axi_txn(1'b0, 32'h0000_0010, '0, '0, resp, rdata, lat);
    check("err_resp", 64'(resp), 64'd2);
    check("err_data", 64'(rdata), 64'd0);
    check("err_lat", 64'(lat), 64'd3);
    tmode[0] = M_BOTH; twait[0] = 0;
    axi_txn(1'b0, 32'h0000_0010, '0, '0, resp, rdata, lat);
    check("ack_err_resp", 64'(resp), 64'd2);
    tmode[0] = M_ACK; twait[0] = 2; extra_err[1] = 1'b1; late_ack[1] = 1'b1;
    axi_txn(1'b0, 32'h0000_0010, '0, '0, resp, rdata, lat);
    extra_err[1] = 1'b0; late_ack[1] = 1'b0;
    check("unsel_resp", 64'(resp), 64'd0);
    check("unsel_data", 64'(rdata), 64'(model[0][4]));
    check("unsel_lat", 64'(lat), 64'd4);

    // Timeout on a silent target, then a late ack that must be ignored
    tmode[1] = M_NEVER; c0 = cyc_cycles; t0 = to_pulses;
    axi_txn(1'b1, 32'h0000_1008, 32'hCAFE_F00D, 4'hF, resp, rdata, lat);
    check("to_resp", 64'(resp), 64'd2);
    check("to_lat", 64'(lat), 64'(TO + 1));
    check("to_cyc_len", 64'(cyc_cycles - c0), 64'(TO));
    check("to_pulse_count", 64'(to_pulses - t0), 64'd1);
    late_ack[1] = 1'b1; c0 = cyc_cycles;
    repeat (3) @(posedge clk);
    #1;
    late_ack[1] = 1'b0;
    check("late_ack_no_valid", 64'({axi.b_valid, axi.r_valid}), 64'd0);
    check("late_ack_no_cyc", 64'(cyc_cycles - c0), 64'd0);
    tmode[1] = M_ACK; twait[1] = 0;
    axi_txn(1'b0, 32'h0000_1008, '0, '0, resp, rdata, lat);
    check("to_no_write", 64'(rdata), 64'(model[1][2]));

    // Asynchronous reset during a Wishbone cycle
    tmode[0] = M_NEVER;
    axi.ar_addr = 32'h0000_0010; axi.ar_valid = 1'b1;
    #1;
    n = 0;
    while (!axi.ar_ready && n < 64) begin @(posedge clk); #2; n++; end
    check("rst_mid_hs", 64'(n < 64), 64'd1);
    @(posedge clk); #1;
    axi.ar_valid = 1'b0; axi.r_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_cyc_before", 64'(wb_cyc), 64'b01);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_cyc_stb", 64'({wb_cyc, wb_stb}), 64'd0);
    check("rst_mid_valids", 64'({axi.r_valid, axi.b_valid}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; axi.r_ready = 1'b0; tmode[0] = M_ACK; twait[0] = 0;
    @(posedge clk); #1;
    axi_txn(1'b0, 32'h0000_0010, '0, '0, resp, rdata, lat);
    check("rst_mid_after_data", 64'(rdata), 64'(model[0][4]));
    check("rst_mid_after_resp", 64'(resp), 64'd0);
    check("rst_mid_after_lat", 64'(lat), 64'd2);

    // Random traffic against the memory-map model
    for (int k = 0; k < 40; k++) begin
      twait[0] = $urandom_range(0, 3);
      twait[1] = $urandom_range(0, 3);
      idx = $urandom_range(0, 15);
      case ($urandom_range(0, 2))
        0: a = 32'h0000_0000;
        1: a = 32'h0000_1000;
        default: a = 32'h0000_8000;
      endcase
      a  = a + 32'(idx * 4);
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      t  = target_of(a);
      exp_lat = (t < 0) ? 1 : int'(twait[t]) + 2;
      axi_txn(wr, a, d, s, resp, rdata, lat);
      check($sformatf("rnd%0d_resp", k), 64'(resp), (t < 0) ? 64'd3 : 64'd0);
      check($sformatf("rnd%0d_lat", k), 64'(lat), 64'(exp_lat));
      if (!wr) check($sformatf("rnd%0d_data", k), 64'(rdata), (t < 0) ? 64'd0 : 64'(model[t][idx]));
      if (wr && t >= 0) model[t][idx] = merge(model[t][idx], d, s);
    end
    check("stb_equals_cyc", 64'(stb_diff), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
